// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the BCD countdown/up timer: FSM states, BCD limits,
// field width and the start-value sanitiser.
package timer_defs;

    localparam int unsigned FIELD_W       = 8;
    localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0]  BCD_MAX_TENS  = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Clamp digits above 9 to 9; lower fields also clamp their tens digit to 5.
    function automatic logic [FIELD_W-1:0] sanitise_field(
        input logic [FIELD_W-1:0] v,
        input logic               is_top
    );
        logic [3:0] ones;
        logic [3:0] tens;
        ones = (v[3:0] > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : v[3:0];
        tens = (v[7:4] > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : v[7:4];
        if (!is_top && (tens > BCD_MAX_TENS)) begin
            tens = BCD_MAX_TENS;
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_field.sv
// One two-digit BCD field: loadable, counts up or down by one when enabled,
// wrapping at 59 (mod-60) or 99 (mod-100).
module bcd_field_counter
    import timer_defs::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_en,
    input  logic               i_dir,
    input  logic               i_mod60,
    input  logic               i_load,
    input  logic [FIELD_W-1:0] i_load_val,
    output logic [FIELD_W-1:0] o_value,
    output logic [FIELD_W-1:0] o_next,
    output logic               o_carry,
    output logic               o_borrow,
    output logic               o_is_zero
);

    logic [FIELD_W-1:0] r_value;
    logic [FIELD_W-1:0] w_next;
    logic [3:0]         w_ones;
    logic [3:0]         w_tens;
    logic [3:0]         w_top_tens;
    logic               w_at_max;
    logic               w_at_zero;

    assign w_ones     = r_value[3:0];
    assign w_tens     = r_value[7:4];
    assign w_top_tens = i_mod60 ? BCD_MAX_TENS : BCD_MAX_DIGIT;
    assign w_at_max   = (w_tens == w_top_tens) && (w_ones == BCD_MAX_DIGIT);
    assign w_at_zero  = (r_value == '0);

    always_comb begin
        w_next = r_value;
        if (i_load) begin
            w_next = i_load_val;
        end else if (i_en) begin
            if (i_dir) begin
                if (w_at_max)                    w_next = '0;
                else if (w_ones == BCD_MAX_DIGIT) w_next = {w_tens + 4'd1, 4'd0};
                else                             w_next = {w_tens, w_ones + 4'd1};
            end else begin
                if (w_at_zero)                   w_next = {w_top_tens, BCD_MAX_DIGIT};
                else if (w_ones == 4'd0)         w_next = {w_tens - 4'd1, BCD_MAX_DIGIT};
                else                             w_next = {w_tens, w_ones - 4'd1};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_value <= '0;
        else         r_value <= w_next;
    end

    assign o_value   = r_value;
    assign o_next    = w_next;
    assign o_carry   = i_en & ~i_load & i_dir & w_at_max;
    assign o_borrow  = i_en & ~i_load & ~i_dir & w_at_zero;
    // Zero flag of the value after this cycle, so the terminal hit needs no extra tick.
    assign o_is_zero = (w_next == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Parametrised BCD match/phase timer: chained BCD fields, pause toggle,
// and the IDLE/RUN/PAUSED/DONE control FSM.
module bcd_countdown_timer
    import timer_defs::*;
#(
    parameter int unsigned FIELDS   = 2,
    parameter logic [2:0]  STATE_ID = 3'd0
)(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic [2:0]                  currentState,
    input  logic                        load,
    input  logic [FIELD_W*FIELDS-1:0]   initialValue,
    input  logic                        count_up,
    input  logic                        pause,
    output logic [FIELD_W*FIELDS-1:0]   digitsOut,
    output logic                        running,
    output logic                        finished,
    output logic                        expired
);

    localparam int unsigned W = FIELD_W * FIELDS;

    state_t         r_state;
    state_t         w_next_state;
    logic [W-1:0]   r_target;
    logic           r_count_up;
    logic           r_was_active;
    logic           r_pause_d;
    logic           r_pause_edge;
    logic           r_expired;

    logic           w_active;
    logic           w_load;
    logic           w_step;
    logic           w_hit;
    logic           w_start_terminal;
    logic [W-1:0]   w_san;
    logic [W-1:0]   w_load_val;
    logic [W-1:0]   w_value;
    logic [W-1:0]   w_next;
    logic [FIELDS-1:0] w_en;
    logic [FIELDS-1:0] w_carry;
    logic [FIELDS-1:0] w_borrow;
    logic [FIELDS-1:0] w_is_zero;

    assign w_active = (currentState == STATE_ID);
    assign w_load   = w_active & (load | ~r_was_active);

    always_comb begin
        w_san = '0;
        for (int unsigned i = 0; i < FIELDS; i++) begin
            w_san[i*FIELD_W +: FIELD_W] =
                sanitise_field(initialValue[i*FIELD_W +: FIELD_W], i == FIELDS - 1);
        end
    end

    assign w_load_val       = count_up ? '0 : w_san;
    // Either mode starts terminal exactly when the sanitised value is zero.
    assign w_start_terminal = (w_san == '0);

    assign w_step = w_active & ~w_load & ~r_pause_edge & tick & (r_state == ST_RUN);

    genvar g;
    generate
        for (g = 0; g < FIELDS; g++) begin : g_field
            if (g == 0) begin : g_first
                assign w_en[g] = w_step;
            end else begin : g_chain
                assign w_en[g] = w_carry[g-1] | w_borrow[g-1];
            end

            bcd_field_counter u_field (
                .i_clk      (clk),
                .i_reset    (reset),
                .i_en       (w_en[g]),
                .i_dir      (r_count_up),
                .i_mod60    (g != FIELDS - 1),
                .i_load     (w_load),
                .i_load_val (w_load_val[g*FIELD_W +: FIELD_W]),
                .o_value    (w_value[g*FIELD_W +: FIELD_W]),
                .o_next     (w_next[g*FIELD_W +: FIELD_W]),
                .o_carry    (w_carry[g]),
                .o_borrow   (w_borrow[g]),
                .o_is_zero  (w_is_zero[g])
            );
        end
    endgenerate

    assign w_hit = r_count_up ? (w_next == r_target) : (&w_is_zero);

    always_comb begin
        w_next_state = r_state;
        if (!w_active) begin
            w_next_state = ST_IDLE;
        end else if (w_load) begin
            w_next_state = w_start_terminal ? ST_DONE : ST_RUN;
        end else if (r_pause_edge && (r_state == ST_RUN)) begin
            w_next_state = ST_PAUSED;
        end else if (r_pause_edge && (r_state == ST_PAUSED)) begin
            w_next_state = ST_RUN;
        end else if (w_step && w_hit) begin
            w_next_state = ST_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_target     <= '0;
            r_count_up   <= 1'b0;
            // Holding currentState through reset must not count as a fresh activation.
            r_was_active <= w_active;
            r_pause_d    <= 1'b0;
            r_pause_edge <= 1'b0;
            r_expired    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_was_active <= w_active;
            r_pause_d    <= pause;
            r_pause_edge <= pause & ~r_pause_d;
            r_expired    <= (w_next_state == ST_DONE) && ((r_state != ST_DONE) || w_load);
            if (w_load) begin
                r_target   <= w_san;
                r_count_up <= count_up;
            end
        end
    end

    assign digitsOut = w_value;
    assign running   = (r_state == ST_RUN);
    assign finished  = (r_state == ST_DONE);
    assign expired   = r_expired;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed self-checking bench for bcd_countdown_timer (FIELDS=2 and FIELDS=3).
module tb_bcd_countdown_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [2:0]  currentState;
    logic        load;
    logic [15:0] initialValue;
    logic [23:0] initialValue3;
    logic        count_up;
    logic        pause;
    logic [15:0] digits;
    logic [23:0] digits3;
    logic        running, finished, expired;
    logic        running3, finished3, expired3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.FIELDS(2), .STATE_ID(3'd0)) dut (
        .clk(clk), .reset(reset), .tick(tick), .currentState(currentState),
        .load(load), .initialValue(initialValue), .count_up(count_up), .pause(pause),
        .digitsOut(digits), .running(running), .finished(finished), .expired(expired)
    );

    bcd_countdown_timer #(.FIELDS(3), .STATE_ID(3'd2)) dut3 (
        .clk(clk), .reset(reset), .tick(tick), .currentState(currentState),
        .load(load), .initialValue(initialValue3), .count_up(count_up), .pause(pause),
        .digitsOut(digits3), .running(running3), .finished(finished3), .expired(expired3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mmss(input int s);
        int m;
        int ss;
        m  = s / 60;
        ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic test_reset();
        reset = 1'b1; tick = 1'b0; load = 1'b0; pause = 1'b0; count_up = 1'b0;
        currentState = 3'd7; initialValue = 16'h0000; initialValue3 = 24'h000000;
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL reset_digits got=%h exp=0000", digits); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
        checks++; if (finished !== 1'b0) begin failures++; $display("FAIL reset_finished got=%b exp=0", finished); end
        checks++; if (expired !== 1'b0) begin failures++; $display("FAIL reset_expired got=%b exp=0", expired); end
        checks++; if (digits3 !== 24'h000000) begin failures++; $display("FAIL reset_digits3 got=%h exp=000000", digits3); end
    endtask

    task automatic test_countdown();
        initialValue = 16'h0102; count_up = 1'b0;
        currentState = 3'd0;
        step();
        checks++; if (digits !== 16'h0102) begin failures++; $display("FAIL act_digits got=%h exp=0102", digits); end
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL act_running got=%b exp=1", running); end
        for (int k = 1; k <= 62; k++) begin
            tick = 1'b1;
            step();
            checks++;
            if (digits !== mmss(62 - k)) begin
                failures++; $display("FAIL countdown_digits tick=%0d got=%h exp=%h", k, digits, mmss(62 - k));
            end
            checks++;
            if (expired !== (k == 62)) begin
                failures++; $display("FAIL countdown_expired tick=%0d got=%b exp=%b", k, expired, (k == 62));
            end
        end
        checks++; if (finished !== 1'b1) begin failures++; $display("FAIL countdown_finished got=%b exp=1", finished); end
        tick = 1'b0;
        step();
        checks++; if (expired !== 1'b0) begin failures++; $display("FAIL countdown_expired_once got=%b exp=0", expired); end
        tick = 1'b1;
        step(); step(); step();
        tick = 1'b0;
        checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL done_hold got=%h exp=0000", digits); end
        checks++; if (finished !== 1'b1) begin failures++; $display("FAIL done_finished got=%b exp=1", finished); end
    endtask

    task automatic test_load_zero();
        initialValue = 16'h0000; count_up = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        checks++; if (finished !== 1'b1) begin failures++; $display("FAIL zero_finished got=%b exp=1", finished); end
        checks++; if (expired !== 1'b1) begin failures++; $display("FAIL zero_expired got=%b exp=1", expired); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL zero_running got=%b exp=0", running); end
        tick = 1'b1;
        step();
        tick = 1'b0;
        checks++; if (expired !== 1'b0) begin failures++; $display("FAIL zero_expired_pulse got=%b exp=0", expired); end
        checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL zero_no_underflow got=%h exp=0000", digits); end
    endtask

    task automatic test_count_up();
        logic [15:0] exp_up [0:2];
        exp_up[0] = 16'h0001; exp_up[1] = 16'h0002; exp_up[2] = 16'h0003;
        initialValue = 16'h0003; count_up = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL up_start got=%h exp=0000", digits); end
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL up_running got=%b exp=1", running); end
        for (int k = 0; k < 3; k++) begin
            tick = 1'b1;
            step();
            checks++;
            if (digits !== exp_up[k]) begin failures++; $display("FAIL up_digits step=%0d got=%h exp=%h", k, digits, exp_up[k]); end
            checks++;
            if (finished !== (k == 2)) begin failures++; $display("FAIL up_finished step=%0d got=%b exp=%b", k, finished, (k == 2)); end
        end
        step(); step();
        tick = 1'b0;
        checks++; if (digits !== 16'h0003) begin failures++; $display("FAIL up_hold got=%h exp=0003", digits); end
        count_up = 1'b0;
    endtask

    task automatic test_pause();
        initialValue = 16'h0012; count_up = 1'b0; load = 1'b1;
        step();
        load = 1'b0; tick = 1'b1;
        step(); step();
        tick = 1'b0;
        checks++; if (digits !== 16'h0010) begin failures++; $display("FAIL pause_pre got=%h exp=0010", digits); end
        pause = 1'b1;
        step();
        tick = 1'b1;
        step();
        checks++; if (digits !== 16'h0010) begin failures++; $display("FAIL pause_tick_dropped got=%h exp=0010", digits); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL pause_running got=%b exp=0", running); end
        step(); step(); step();
        tick = 1'b0;
        checks++; if (digits !== 16'h0010) begin failures++; $display("FAIL paused_hold got=%h exp=0010", digits); end
        pause = 1'b0;
        step();
        pause = 1'b1;
        step();
        step();
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL resume_running got=%b exp=1", running); end
        tick = 1'b1;
        step();
        tick = 1'b0; pause = 1'b0;
        checks++; if (digits !== 16'h0009) begin failures++; $display("FAIL resume_tick got=%h exp=0009", digits); end
        step();
    endtask

    task automatic test_sanitise();
        initialValue = 16'h9A7C; count_up = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        checks++; if (digits !== 16'h9959) begin failures++; $display("FAIL sanitise_load got=%h exp=9959", digits); end
        tick = 1'b1;
        step();
        tick = 1'b0;
        checks++; if (digits !== 16'h9958) begin failures++; $display("FAIL sanitise_tick got=%h exp=9958", digits); end
    endtask

    task automatic test_fields3();
        initialValue3 = 24'h010000;
        currentState = 3'd2;
        step();
        checks++; if (digits3 !== 24'h010000) begin failures++; $display("FAIL f3_load got=%h exp=010000", digits3); end
        checks++; if (running3 !== 1'b1) begin failures++; $display("FAIL f3_running got=%b exp=1", running3); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL f2_idle_running got=%b exp=0", running); end
        tick = 1'b1;
        step();
        tick = 1'b0;
        checks++; if (digits3 !== 24'h005959) begin failures++; $display("FAIL f3_borrow got=%h exp=005959", digits3); end
        checks++; if ((finished3 | expired3) !== 1'b0) begin failures++; $display("FAIL f3_not_done got=%b exp=0", finished3 | expired3); end
        checks++; if (digits !== 16'h9958) begin failures++; $display("FAIL f2_frozen got=%h exp=9958", digits); end
    endtask

    task automatic test_reset_mid();
        initialValue = 16'h0040; count_up = 1'b0;
        currentState = 3'd0;
        step();
        tick = 1'b1;
        for (int k = 0; k < 10; k++) step();
        tick = 1'b0;
        checks++; if (digits !== 16'h0030) begin failures++; $display("FAIL mid_pre got=%h exp=0030", digits); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (digits !== 16'h0000) begin failures++; $display("FAIL mid_reset_digits got=%h exp=0000", digits); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL mid_reset_running got=%b exp=0", running); end
        tick = 1'b1;
        step(); step();
        tick = 1'b0;
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL mid_no_restart got=%b exp=0", running); end
        load = 1'b1;
        step();
        load = 1'b0;
        checks++; if (digits !== 16'h0040) begin failures++; $display("FAIL mid_reload got=%h exp=0040", digits); end
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL mid_reload_running got=%b exp=1", running); end
    endtask

    task automatic test_deactivate();
        tick = 1'b1;
        for (int k = 0; k < 5; k++) step();
        tick = 1'b0;
        checks++; if (digits !== 16'h0035) begin failures++; $display("FAIL deact_pre got=%h exp=0035", digits); end
        currentState = 3'd1;
        step();
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL deact_running got=%b exp=0", running); end
        tick = 1'b1;
        step();
        tick = 1'b0;
        checks++; if (digits !== 16'h0035) begin failures++; $display("FAIL deact_frozen got=%h exp=0035", digits); end
        currentState = 3'd0;
        step();
        checks++; if (digits !== 16'h0040) begin failures++; $display("FAIL react_reload got=%h exp=0040", digits); end
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL react_running got=%b exp=1", running); end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_load_zero();
        test_count_up();
        test_pause();
        test_sanitise();
        test_fields3();
        test_reset_mid();
        test_deactivate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
